// File: rtl/sprite_line_engine_if.sv
// Host/ROM/line-buffer bundle for the sprite line engine.
// slave = engine side, master = controller/memory side.
interface sprite_line_engine_if;
  logic        line_start;
  logic [9:0]  next_row;
  logic        attr_we;
  logic [2:0]  attr_idx;
  logic [25:0] attr_data;
  logic [5:0]  rom_sprite;
  logic [2:0]  rom_row;
  logic [2:0]  rom_col;
  logic [1:0]  rom_pixel;
  logic        lb_write;
  logic [9:0]  lb_addr;
  logic [1:0]  lb_data;
  logic        busy;
  logic        done;
  logic [3:0]  hit_count;

  modport slave (
    input  line_start, next_row, attr_we, attr_idx, attr_data, rom_pixel,
    output rom_sprite, rom_row, rom_col, lb_write, lb_addr, lb_data, busy, done, hit_count
  );
  modport master (
    output line_start, next_row, attr_we, attr_idx, attr_data, rom_pixel,
    input  rom_sprite, rom_row, rom_col, lb_write, lb_addr, lb_data, busy, done, hit_count
  );
endinterface

// File: rtl/sprite_line_engine.sv
// Builds one raster line: clears a line-buffer bank, then paints every sprite
// hitting the row from slot 7 down to 0 so lower slots end up on top.
module sprite_line_engine #(
  parameter int NUM_SPRITES = 8,
  parameter int LB_WIDTH    = 512
) (
  input logic           clock,
  input logic           reset,
  sprite_line_engine_if.slave bus
);
  localparam logic [2:0] LAST_SLOT = 3'(NUM_SPRITES - 1);
  localparam logic [8:0] LAST_X    = 9'(LB_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, EVAL, DRAW, DONE} state_t;

  state_t      state_q, state_d;
  logic [8:0]  clr_x_q, clr_x_d;
  logic [2:0]  slot_q, slot_d;
  logic [4:0]  dx_q, dx_d;
  logic [9:0]  row_q, row_d;
  logic        bank_q, bank_d;
  logic [5:0]  cur_num_q, cur_num_d;
  logic [2:0]  cur_row_q, cur_row_d;
  logic [9:0]  cur_x_q, cur_x_d;
  logic        wr_vld_q, wr_vld_d;
  logic [8:0]  wr_x_q, wr_x_d;
  logic [3:0]  hits_q, hits_d;
  logic [3:0]  hit_count_q, hit_count_d;
  logic [25:0] attr_q [NUM_SPRITES];
  logic [25:0] attr_d [NUM_SPRITES];

  logic [25:0] ev_attr;
  logic [9:0]  ev_dy;
  logic        ev_hit;

  always_comb begin
    ev_attr = attr_q[slot_q];
    ev_dy   = row_q - ev_attr[19:10];
    ev_hit  = (ev_attr[25:20] != 6'd0) && (ev_dy < 10'd16);
  end

  always_comb begin
    state_d     = state_q;
    clr_x_d     = clr_x_q;
    slot_d      = slot_q;
    dx_d        = dx_q;
    row_d       = row_q;
    bank_d      = bank_q;
    cur_num_d   = cur_num_q;
    cur_row_d   = cur_row_q;
    cur_x_d     = cur_x_q;
    wr_vld_d    = 1'b0;
    wr_x_d      = wr_x_q;
    hits_d      = hits_q;
    hit_count_d = hit_count_q;
    attr_d      = attr_q;
    bus.rom_sprite = 6'd0;
    bus.rom_row    = 3'd0;
    bus.rom_col    = 3'd0;
    bus.lb_write   = 1'b0;
    bus.lb_addr    = 10'd0;
    bus.lb_data    = 2'd0;

    if (bus.attr_we) attr_d[bus.attr_idx] = bus.attr_data;

    // A DRAW write lands one cycle after its issue, when the ROM data arrives.
    if (wr_vld_q) begin
      bus.lb_addr  = {bank_q, wr_x_q};
      bus.lb_data  = bus.rom_pixel;
      bus.lb_write = (bus.rom_pixel != 2'd0);
    end

    unique case (state_q)
      IDLE: begin
        if (bus.line_start) begin
          row_d   = bus.next_row;
          bank_d  = bus.next_row[0];
          clr_x_d = 9'd0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        bus.lb_write = 1'b1;
        bus.lb_addr  = {bank_q, clr_x_q};
        if (clr_x_q == LAST_X) begin
          slot_d  = LAST_SLOT;
          hits_d  = 4'd0;
          state_d = EVAL;
        end else begin
          clr_x_d = clr_x_q + 9'd1;
        end
      end
      EVAL: begin
        if (ev_hit) begin
          cur_num_d = ev_attr[25:20];
          cur_row_d = ev_dy[3:1];
          cur_x_d   = ev_attr[9:0];
          dx_d      = 5'd0;
          hits_d    = hits_q + 4'd1;
          state_d   = DRAW;
        end else if (slot_q == 3'd0) begin
          hit_count_d = hits_q;
          state_d     = DONE;
        end else begin
          slot_d = slot_q - 3'd1;
        end
      end
      DRAW: begin
        if (!dx_q[4]) begin
          bus.rom_sprite = cur_num_q;
          bus.rom_row    = cur_row_q;
          bus.rom_col    = dx_q[3:1];
          wr_vld_d       = 1'b1;
          wr_x_d         = 9'(cur_x_q + {6'd0, dx_q[3:0]});
          dx_d           = dx_q + 5'd1;
        end else if (slot_q == 3'd0) begin
          hit_count_d = hits_q;
          state_d     = DONE;
        end else begin
          slot_d  = slot_q - 3'd1;
          state_d = EVAL;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q == CLEAR) || (state_q == EVAL) || (state_q == DRAW);
  assign bus.done      = (state_q == DONE);
  assign bus.hit_count = hit_count_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      clr_x_q     <= 9'd0;
      slot_q      <= 3'd0;
      dx_q        <= 5'd0;
      row_q       <= 10'd0;
      bank_q      <= 1'b0;
      cur_num_q   <= 6'd0;
      cur_row_q   <= 3'd0;
      cur_x_q     <= 10'd0;
      wr_vld_q    <= 1'b0;
      wr_x_q      <= 9'd0;
      hits_q      <= 4'd0;
      hit_count_q <= 4'd0;
      attr_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      clr_x_q     <= clr_x_d;
      slot_q      <= slot_d;
      dx_q        <= dx_d;
      row_q       <= row_d;
      bank_q      <= bank_d;
      cur_num_q   <= cur_num_d;
      cur_row_q   <= cur_row_d;
      cur_x_q     <= cur_x_d;
      wr_vld_q    <= wr_vld_d;
      wr_x_q      <= wr_x_d;
      hits_q      <= hits_d;
      hit_count_q <= hit_count_d;
      attr_q      <= attr_d;
    end
  end
endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed bench: a line-level model predicts every cycle of each fill and the
// final line-buffer bank; a few hand-computed pixels and done cycles pin the model.
module tb_sprite_line_engine;
  localparam int MAXC = 600;

  logic clock;
  logic reset;
  sprite_line_engine_if bus ();

  sprite_line_engine #(.NUM_SPRITES(8), .LB_WIDTH(512)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [1:0] rom_fn(input int num, input int row, input int col);
    return 2'((num * 7 + row * 3 + col * 5) & 3);
  endfunction

  // Synchronous sprite ROM: data one cycle after the address.
  always @(posedge clock) bus.rom_pixel <= rom_fn(bus.rom_sprite, bus.rom_row, bus.rom_col);

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, exp_done = 0, exp_hits = 0, done_cyc = 0;
  bit chk_en = 0, done_seen = 0;
  logic       exp_bank;
  logic [9:0] fill_row;
  logic       exp_wr   [MAXC];
  logic [9:0] exp_addr [MAXC];
  logic [1:0] exp_dat  [MAXC];
  logic [5:0] exp_rs   [MAXC];
  logic [2:0] exp_rr   [MAXC];
  logic [2:0] exp_rc   [MAXC];
  logic [1:0] exp_lb   [512];
  logic [1:0] sh_lb    [2][512];
  logic [5:0] sh_num [8];
  logic [9:0] sh_y   [8];
  logic [9:0] sh_x   [8];

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp_v);
    end
  endtask

  // Line model: clear cycles 1..512, one EVAL cycle per slot from 513,
  // each hit adds 16 issue cycles + 1 drain with writes trailing issues by 1.
  task automatic build_model(input logic [9:0] row);
    int c;
    logic [9:0] dy;
    logic [1:0] p;
    exp_bank = row[0];
    for (int i = 0; i < MAXC; i++) begin
      exp_wr[i] = 0; exp_addr[i] = 0; exp_dat[i] = 0;
      exp_rs[i] = 0; exp_rr[i] = 0; exp_rc[i] = 0;
    end
    for (int i = 0; i < 512; i++) begin
      exp_wr[1 + i] = 1;
      exp_addr[1 + i] = {exp_bank, 9'(i)};
      exp_lb[i] = 0;
    end
    c = 513;
    exp_hits = 0;
    for (int s = 7; s >= 0; s--) begin
      dy = row - sh_y[s];
      if (sh_num[s] != 0 && dy < 16) begin
        exp_hits++;
        for (int dx = 0; dx < 16; dx++) begin
          exp_rs[c + 1 + dx] = sh_num[s];
          exp_rr[c + 1 + dx] = 3'(dy >> 1);
          exp_rc[c + 1 + dx] = 3'(dx >> 1);
          p = rom_fn(sh_num[s], dy >> 1, dx >> 1);
          if (p != 0) begin
            exp_wr[c + 2 + dx]   = 1;
            exp_addr[c + 2 + dx] = {exp_bank, 9'((sh_x[s] + dx) % 512)};
            exp_dat[c + 2 + dx]  = p;
            exp_lb[(sh_x[s] + dx) % 512] = p;
          end
        end
        c += 17;
      end
      c += 1;
    end
    exp_done = c;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      cyc++;
      if (cyc >= MAXC) begin
        chk("cycle_budget", cyc, exp_done);
        chk_en = 0;
      end else begin
        if (bus.lb_write) sh_lb[bus.lb_addr[9]][bus.lb_addr[8:0]] = bus.lb_data;
        chk("lb_write", bus.lb_write, exp_wr[cyc]);
        if (exp_wr[cyc]) begin
          chk("lb_addr", bus.lb_addr, exp_addr[cyc]);
          chk("lb_data", bus.lb_data, exp_dat[cyc]);
        end
        chk("rom_sprite", bus.rom_sprite, exp_rs[cyc]);
        chk("rom_row", bus.rom_row, exp_rr[cyc]);
        chk("rom_col", bus.rom_col, exp_rc[cyc]);
        chk("busy", bus.busy, cyc < exp_done);
        chk("done", bus.done, cyc == exp_done);
        if (bus.done) done_cyc = cyc;
        if (cyc >= exp_done) begin
          chk("hit_count", bus.hit_count, exp_hits);
          for (int x = 0; x < 512; x++) chk("lb_final", sh_lb[exp_bank][x], exp_lb[x]);
          done_seen = 1;
          chk_en = 0;
        end
      end
    end
  end

  task automatic write_attr(input int idx, input int num, input int y, input int x);
    bus.attr_we   = 1;
    bus.attr_idx  = 3'(idx);
    bus.attr_data = {6'(num), 10'(y), 10'(x)};
    @(posedge clock); #1;
    bus.attr_we = 0;
    sh_num[idx] = 6'(num); sh_y[idx] = 10'(y); sh_x[idx] = 10'(x);
  endtask

  task automatic start_fill(input logic [9:0] row);
    bus.line_start = 1;
    bus.next_row   = row;
    fill_row       = row;
    build_model(row);
    for (int b = 0; b < 2; b++) for (int x = 0; x < 512; x++) sh_lb[b][x] = 2'd3;
    @(posedge clock); #1;
    bus.line_start = 0;
    cyc = 0;
    done_seen = 0;
    done_cyc = 0;
    chk_en = 1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1000 && !done_seen; i++) @(posedge clock);
    #1;
    if (!done_seen) begin
      chk("fill_timeout", 0, 1);
      chk_en = 0;
    end
  endtask

  task automatic clear_shadow();
    for (int s = 0; s < 8; s++) begin sh_num[s] = 0; sh_y[s] = 0; sh_x[s] = 0; end
  endtask

  initial begin
    int dcount;
    reset = 0;
    bus.line_start = 0; bus.next_row = 0;
    bus.attr_we = 0; bus.attr_idx = 0; bus.attr_data = 0;
    clear_shadow();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_lb_write", bus.lb_write, 0);
    chk("rst_hit_count", bus.hit_count, 0);
    chk("rst_rom_sprite", bus.rom_sprite, 0);
    reset = 1;
    @(posedge clock); #1;

    // All slots disabled.
    start_fill(10'd100);
    wait_done();
    chk("A_done_cyc", done_cyc, 521);

    // Single sprite, odd row -> bank 1.
    write_attr(2, 5, 96, 40);
    start_fill(10'd101);
    wait_done();
    chk("B_done_cyc", done_cyc, 538);
    chk("B_lb40", sh_lb[1][40], 1);
    chk("B_lb46", sh_lb[1][46], 0);
    chk("B_lb52", sh_lb[1][52], 3);

    // Overlapping slots 0 and 1: slot 0 wins unless transparent.
    write_attr(2, 0, 0, 0);
    write_attr(0, 9, 50, 10);
    write_attr(1, 3, 50, 10);
    start_fill(10'd60);
    wait_done();
    chk("C_done_cyc", done_cyc, 555);
    chk("C_lb10", sh_lb[0][10], 2);
    chk("C_lb12", sh_lb[0][12], 3);
    chk("C_lb14", sh_lb[0][14], 2);

    // X wrap, Y wrap, dy=16 miss, dy=15 hit.
    write_attr(0, 0, 0, 0);
    write_attr(1, 0, 0, 0);
    write_attr(3, 12, 1020, 505);
    write_attr(4, 1, 1011, 100);
    write_attr(5, 2, 1012, 200);
    start_fill(10'd3);
    wait_done();
    chk("D_done_cyc", done_cyc, 555);
    chk("D_hits", bus.hit_count, 2);
    chk("D_lb505", sh_lb[1][505], 1);
    chk("D_lb0", sh_lb[1][0], 0);
    chk("D_lb1", sh_lb[1][1], 1);

    // line_start while busy is ignored; reset mid-clear aborts the fill.
    start_fill(10'd7);
    repeat (99) @(posedge clock);
    #1;
    bus.line_start = 1; bus.next_row = 10'd8;
    @(posedge clock); #1;
    bus.line_start = 0;
    repeat (99) @(posedge clock);
    #1;
    chk_en = 0;
    reset = 0;
    @(posedge clock); #1;
    chk("E_busy", bus.busy, 0);
    chk("E_lb_write", bus.lb_write, 0);
    chk("E_done", bus.done, 0);
    chk("E_hit_count", bus.hit_count, 0);
    reset = 1;
    clear_shadow();
    dcount = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (bus.done) dcount++;
    end
    chk("E_no_done", dcount, 0);
    @(posedge clock); #1;

    // Attribute written during CLEAR is used in its EVAL.
    start_fill(10'd20);
    repeat (49) @(posedge clock);
    #1;
    write_attr(0, 7, 18, 300);
    build_model(fill_row);
    wait_done();
    chk("F_done_cyc", done_cyc, 538);
    chk("F_lb300", sh_lb[0][300], 0);
    chk("F_lb302", sh_lb[0][302], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
